// File: rtl/syrk_stream_wrapper.sv
// syrk_stream_wrapper
//   Power-characterisation wrapper around a 4-lane SYRK-style kernel.
//   A and C_in are generated from counters. The kernel computes
//   C = ALPHA*A*A^T + BETA*C_in on the lower triangle and passes C_in
//   through above the diagonal. Lane p owns rows i with i mod 4 = p.
//   Every written word is XOR-folded into a 32-bit checksum, which is then
//   shifted out one nibble per cycle, least significant nibble first.
// Ports:
//   ap_clk      rising-edge system clock
//   ap_rst_n    asynchronous active-low reset
//   probe_out   high while the kernel is computing
//   data_out    checksum nibble
//   data_valid  qualifies data_out (8 consecutive cycles)
module syrk_stream_wrapper #(
  parameter int N     = 4,
  parameter int M     = 4,
  parameter int ALPHA = 2,
  parameter int BETA  = 3,
  parameter int DW    = 32
) (
  input  logic       ap_clk,
  input  logic       ap_rst_n,
  output logic       probe_out,
  output logic [3:0] data_out,
  output logic       data_valid
);

  localparam logic [31:0] K_LAST = 32'(M);
  localparam logic [31:0] J_LAST = 32'(N - 1);
  localparam logic [31:0] R_LAST = 32'(N / 4 - 1);

  typedef enum logic [1:0] {S_RUN, S_SER, S_DONE} state_t;

  state_t          state;
  logic [31:0]     k_cnt;     // MAC step inside the slot; K_LAST marks the write cycle
  logic [31:0]     j_cnt;     // column index
  logic [31:0]     r_cnt;     // row index local to a lane (i = 4*r + p)
  logic [2:0]      nib_cnt;
  logic [DW-1:0]   acc [4];
  logic [31:0]     ck;
  logic [31:0]     ck_next;
  logic [DW-1:0]   wr_xor;
  logic [DW-1:0]   mac_prod [4];
  logic [7:0]      a_col;

  logic            C_out_0_write, C_out_1_write, C_out_2_write, C_out_3_write;
  logic [DW-1:0]   C_out_0_din, C_out_1_din, C_out_2_din, C_out_3_din;

  // A[i][k] = (i*M + k + 1) mod 256
  function automatic logic [7:0] a_val(input logic [31:0] i, input logic [31:0] k);
    a_val = 8'(i * K_LAST + k + 32'd1);
  endfunction

  // Lower triangle gets the scaled product, upper triangle is C_in passthrough
  function automatic logic [DW-1:0] elem(input logic [31:0] i, input logic [31:0] j,
                                         input logic [DW-1:0] acc_v);
    logic [DW-1:0] cin;
    cin = DW'(i + j);
    if (j <= i) elem = DW'(ALPHA) * acc_v + DW'(BETA) * cin;
    else        elem = cin;
  endfunction

  // Per-lane A[i][k]*A[j][k]; the column operand is shared by all lanes
  always_comb begin
    a_col = a_val(j_cnt, k_cnt);
    for (int p = 0; p < 4; p++) begin
      mac_prod[p] = DW'({8'd0, a_val(r_cnt * 32'd4 + 32'(p), k_cnt)} * {8'd0, a_col});
    end
  end

  // Checksum including whatever the lanes are presenting this cycle, so the
  // first serialised nibble already covers the final write
  always_comb begin
    wr_xor = '0;
    if (C_out_0_write) wr_xor = wr_xor ^ C_out_0_din;
    if (C_out_1_write) wr_xor = wr_xor ^ C_out_1_din;
    if (C_out_2_write) wr_xor = wr_xor ^ C_out_2_din;
    if (C_out_3_write) wr_xor = wr_xor ^ C_out_3_din;
    ck_next = ck ^ 32'(wr_xor);
  end

  // Kernel sequencing, lane registers, checksum and pin registers
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state         <= S_RUN;
      k_cnt         <= 32'd0;
      j_cnt         <= 32'd0;
      r_cnt         <= 32'd0;
      nib_cnt       <= 3'd0;
      ck            <= 32'd0;
      probe_out     <= 1'b0;
      data_out      <= 4'd0;
      data_valid    <= 1'b0;
      C_out_0_write <= 1'b0;
      C_out_1_write <= 1'b0;
      C_out_2_write <= 1'b0;
      C_out_3_write <= 1'b0;
      C_out_0_din   <= '0;
      C_out_1_din   <= '0;
      C_out_2_din   <= '0;
      C_out_3_din   <= '0;
      for (int p = 0; p < 4; p++) acc[p] <= '0;
    end else begin
      ck <= ck_next;
      case (state)
        S_RUN: begin
          probe_out <= 1'b1;
          if (k_cnt != K_LAST) begin
            C_out_0_write <= 1'b0;
            C_out_1_write <= 1'b0;
            C_out_2_write <= 1'b0;
            C_out_3_write <= 1'b0;
            for (int p = 0; p < 4; p++) acc[p] <= acc[p] + mac_prod[p];
            k_cnt <= k_cnt + 32'd1;
          end else begin
            C_out_0_write <= 1'b1;
            C_out_1_write <= 1'b1;
            C_out_2_write <= 1'b1;
            C_out_3_write <= 1'b1;
            C_out_0_din   <= elem(r_cnt * 32'd4 + 32'd0, j_cnt, acc[0]);
            C_out_1_din   <= elem(r_cnt * 32'd4 + 32'd1, j_cnt, acc[1]);
            C_out_2_din   <= elem(r_cnt * 32'd4 + 32'd2, j_cnt, acc[2]);
            C_out_3_din   <= elem(r_cnt * 32'd4 + 32'd3, j_cnt, acc[3]);
            for (int p = 0; p < 4; p++) acc[p] <= '0;
            k_cnt <= 32'd0;
            if (j_cnt == J_LAST) begin
              j_cnt <= 32'd0;
              if (r_cnt == R_LAST) state <= S_SER;
              else                 r_cnt <= r_cnt + 32'd1;
            end else begin
              j_cnt <= j_cnt + 32'd1;
            end
          end
        end
        S_SER: begin
          probe_out     <= 1'b0;
          C_out_0_write <= 1'b0;
          C_out_1_write <= 1'b0;
          C_out_2_write <= 1'b0;
          C_out_3_write <= 1'b0;
          data_valid    <= 1'b1;
          data_out      <= ck_next[{nib_cnt, 2'b00} +: 4];
          nib_cnt       <= nib_cnt + 3'd1;
          if (nib_cnt == 3'd7) state <= S_DONE;
        end
        S_DONE: begin
          probe_out     <= 1'b0;
          data_valid    <= 1'b0;
          data_out      <= 4'd0;
          C_out_0_write <= 1'b0;
          C_out_1_write <= 1'b0;
          C_out_2_write <= 1'b0;
          C_out_3_write <= 1'b0;
        end
        default: begin
          state <= S_DONE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_syrk_stream_wrapper.sv
// Directed bench for syrk_stream_wrapper with default parameters.
module tb_syrk_stream_wrapper;

  logic       ap_clk;
  logic       ap_rst_n;
  logic       probe_out;
  logic [3:0] data_out;
  logic       data_valid;

  int vectors;
  int miscompares;

  // Hand-computed lane outputs: row i = lane p, columns j = 0..3
  int unsigned exp_tab [4][4] = '{
    '{32'd60,  32'd1,   32'd2,    32'd3},
    '{32'd143, 32'd354, 32'd3,    32'd4},
    '{32'd226, 32'd565, 32'd904,  32'd5},
    '{32'd309, 32'd776, 32'd1243, 32'd1710}
  };

  syrk_stream_wrapper dut (
    .ap_clk     (ap_clk),
    .ap_rst_n   (ap_rst_n),
    .probe_out  (probe_out),
    .data_out   (data_out),
    .data_valid (data_valid)
  );

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  function automatic logic lane_write(input int p);
    case (p)
      0:       lane_write = dut.C_out_0_write;
      1:       lane_write = dut.C_out_1_write;
      2:       lane_write = dut.C_out_2_write;
      default: lane_write = dut.C_out_3_write;
    endcase
  endfunction

  function automatic logic [31:0] lane_din(input int p);
    case (p)
      0:       lane_din = dut.C_out_0_din;
      1:       lane_din = dut.C_out_1_din;
      2:       lane_din = dut.C_out_2_din;
      default: lane_din = dut.C_out_3_din;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  task automatic check_all_low(input string tag);
    check({tag, "_probe"}, {31'd0, probe_out}, 32'd0);
    check({tag, "_valid"}, {31'd0, data_valid}, 32'd0);
    check({tag, "_data"}, {28'd0, data_out}, 32'd0);
    check({tag, "_writes"}, {28'd0, lane_write(3), lane_write(2), lane_write(1), lane_write(0)}, 32'd0);
  endtask

  // Cycle c is sampled on the falling edge after the c-th rising edge since release
  task automatic run_and_check(input int n_cyc);
    logic [31:0] ck_model;
    logic [31:0] reassembled;
    int          nvalid;
    int          nwrites [4];
    logic        exp_w;
    logic        exp_v;
    ck_model    = 32'd0;
    reassembled = 32'd0;
    nvalid      = 0;
    for (int p = 0; p < 4; p++) nwrites[p] = 0;
    for (int c = 0; c < n_cyc; c++) begin
      @(posedge ap_clk);
      @(negedge ap_clk);
      check($sformatf("probe_c%0d", c), {31'd0, probe_out}, {31'd0, (c <= 19)});
      exp_w = (c % 5 == 4) && (c <= 19);
      for (int p = 0; p < 4; p++) begin
        check($sformatf("write_l%0d_c%0d", p, c), {31'd0, lane_write(p)}, {31'd0, exp_w});
        if (lane_write(p)) nwrites[p]++;
        if (exp_w) begin
          check($sformatf("din_l%0d_e%0d", p, c / 5), lane_din(p), exp_tab[p][c / 5]);
          ck_model = ck_model ^ exp_tab[p][c / 5];
        end
      end
      exp_v = (c >= 20) && (c <= 27);
      check($sformatf("valid_c%0d", c), {31'd0, data_valid}, {31'd0, exp_v});
      if (data_valid) begin
        reassembled = reassembled | ({28'd0, data_out} << (4 * nvalid));
        nvalid++;
      end
      if (exp_v)
        check($sformatf("nibble_c%0d", c), {28'd0, data_out}, {28'd0, ck_model[4 * (c - 20) +: 4]});
      else
        check($sformatf("data_low_c%0d", c), {28'd0, data_out}, 32'd0);
    end
    if (n_cyc >= 28) begin
      for (int p = 0; p < 4; p++)
        check($sformatf("nwrites_l%0d", p), nwrites[p], 32'd4);
      check("nvalid", nvalid, 32'd8);
      check("checksum", reassembled, ck_model);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    ap_rst_n    = 1'b0;

    // Long reset: everything held low
    for (int c = 0; c < 50; c++) begin
      @(negedge ap_clk);
      check_all_low($sformatf("rst_c%0d", c));
    end
    ap_rst_n = 1'b1;

    // Full run from release, including serialisation and idle tail
    run_and_check(36);

    // Fresh start, then reset mid-computation at cycle 12
    ap_rst_n = 1'b0;
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    run_and_check(13);
    ap_rst_n = 1'b0;
    #1;
    check_all_low("midrst_now");
    for (int c = 0; c < 3; c++) begin
      @(negedge ap_clk);
      check_all_low($sformatf("midrst_c%0d", c));
    end
    ap_rst_n = 1'b1;
    run_and_check(36);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
